slot_mem_port: RTL and testbench
================================

Name: slot_mem_port

Overview:
- Memory-side responder for the byte-wide cartridge memory request bus driven by the slot logic: addr, din, we, rd, dout, ready.
- Converts byte reads and writes into word transactions on the 16-bit SDRAM controller request/ack port.
- Holds a one-word read cache so sequential Z80 fetches from the same word complete with zero wait.
- Sits between the slot block and the SDRAM controller.

Parameters:
- ADDR_W, 25, byte address width of the slot side.
- CACHE_EN, 1, 1 = one-word read cache enabled; 0 = every read goes to memory.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- addr  in  ADDR_W  byte address from slot logic.
- din  in  8  write data byte.
- we  in  1  write request; level, rising edge starts a write.
- rd  in  1  read request; level, held with stable addr.
- dout  out  8  read data; valid while ready=1 and rd=1.
- ready  out  1  1 = no access outstanding and dout valid for the current addr.
- mem_addr  out  ADDR_W-1  word address (addr[ADDR_W-1:1]).
- mem_din  out  16  write word; din replicated on both bytes.
- mem_be  out  2  byte enables; [0] = even byte, [1] = odd byte.
- mem_we  out  1  1 = write transaction, 0 = read.
- mem_req  out  1  request; held high until mem_ack.
- mem_ack  in  1  one-cycle completion pulse from the controller.
- mem_dout  in  16  read word; valid in the mem_ack cycle.

Behaviour:
- States:
  - IDLE: no access in flight.
  - RD_BUSY: mem_req=1, mem_we=0.
  - WR_BUSY: mem_req=1, mem_we=1.
- Registered state: last_addr (ADDR_W), last_valid, cache_tag (ADDR_W-1), cache_word (16), cache_valid, we_d.
- Reset values: state=IDLE, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_din=0, dout=FF, last_valid=0, cache_valid=0, we_d=0. ready therefore reads 1 after reset when rd=0 and we=0.
- Start conditions, evaluated in IDLE:
  - wr_start = we & ~we_d.
  - rd_new = rd & (~last_valid | addr != last_addr).
  - hit = CACHE_EN & cache_valid & addr[ADDR_W-1:1] == cache_tag.
- ready is combinational: ready = (state==IDLE) & ~wr_start & ~(rd_new & ~hit). It drops in the same cycle a miss or write is presented, so the requester never samples a stale 1.
- Read hit (rd_new & hit, no write): no memory access. dout = cache byte selected by addr[0], same cycle. last_addr <= addr, last_valid <= 1.
- Read miss (rd_new & ~hit):
  - Next cycle: RD_BUSY, mem_addr = addr[ADDR_W-1:1], mem_req = 1.
  - On mem_ack: cache_word <= mem_dout, cache_tag <= mem_addr, cache_valid <= 1. dout latched from the byte selected by addr[0]. last_addr and last_valid updated. Return to IDLE; ready=1 the cycle after ack.
  - Minimum miss latency: 2 cycles plus controller latency.
- Write (wr_start):
  - Next cycle: WR_BUSY, mem_be = addr[0] ? 10 : 01, mem_din = {din, din}.
  - On mem_ack: return to IDLE.
  - If the write tag equals cache_tag and cache_valid=1, the selected cached byte is replaced with din at the start cycle (write-through, cache stays coherent).
  - last_valid <= 0, forcing the next read to re-evaluate.
- Simultaneous wr_start and rd_new: write wins; the read is re-evaluated in IDLE after the write completes.
- we_d tracks we every cycle, including while busy. A we rising edge while busy is not queued; the requester must wait for ready=1. The bench asserts this.
- rd deasserted during RD_BUSY: the transaction still completes and the cache is filled; dout is updated.
- mem_addr, mem_din, mem_be and mem_we stay stable while mem_req=1. mem_req drops the cycle after mem_ack.
- A mem_ack received in IDLE is ignored.
- addr changes while busy have no effect until IDLE.
- Reset mid-operation returns all registers to reset values immediately. The controller must tolerate the abandoned request.

Test Plan:
- Reset, then rd=1 addr=0x000100 -> ready=0 same cycle; mem_req=1 next cycle with mem_addr=0x000080. Controller acks 3 cycles later with mem_dout=0xBEEF -> dout=0xEF, ready=1 the cycle after ack.
- Following the above, addr=0x000101 with rd held -> ready stays 1, dout=0xBE, mem_req never asserts (cache hit). Repeat with CACHE_EN=0 -> a memory read is issued.
- we pulse addr=0x000101 din=0x5A -> mem_we=1, mem_be=10, mem_din=0x5A5A. Cached word becomes 0x5AEF; a subsequent read of 0x000100 returns 0xEF with no memory access.
- 256-byte write burst (one we pulse per ack) -> exactly 256 mem_req transactions, no lost or duplicated writes.
- rd and we rising in the same cycle at different words -> write issued first, then read; final dout matches memory.
- Assert reset during RD_BUSY -> mem_req=0, ready=1, dout=FF immediately. The next read of the same address misses (cache invalid).

Source files
------------

// File: rtl/slot_mem_port.sv
// Byte-wide slot memory responder: turns slot byte reads/writes into 16-bit
// SDRAM controller request/ack transactions, with a one-word read cache.
module slot_mem_port #(
  parameter int ADDR_W   = 25,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        din,
  input  logic              we,
  input  logic              rd,
  output logic [7:0]        dout,
  output logic              ready,
  output logic [ADDR_W-2:0] mem_addr,
  output logic [15:0]       mem_din,
  output logic [1:0]        mem_be,
  output logic              mem_we,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [15:0]       mem_dout
);

  typedef enum logic [1:0] {IDLE, RD_BUSY, WR_BUSY} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-2:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_din_q, mem_din_d;
  logic [1:0]        mem_be_q, mem_be_d;
  logic [7:0]        dout_q, dout_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic              last_valid_q, last_valid_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [ADDR_W-2:0] cache_tag_q, cache_tag_d;
  logic [15:0]       cache_word_q, cache_word_d;
  logic              cache_valid_q, cache_valid_d;
  logic              we_prev_q, we_prev_d;

  logic              wr_start, rd_new, hit, tag_match;
  logic [7:0]        hit_byte;

  assign tag_match = cache_valid_q && (addr[ADDR_W-1:1] == cache_tag_q);
  assign wr_start  = we && !we_prev_q;
  assign rd_new    = rd && (!last_valid_q || (addr != last_addr_q));
  assign hit       = CACHE_EN && tag_match;
  assign hit_byte  = addr[0] ? cache_word_q[15:8] : cache_word_q[7:0];

  // Ready must fall combinationally so a miss or write is never seen as done.
  assign ready    = (state_q == IDLE) && !wr_start && !(rd_new && !hit);
  assign dout     = ((state_q == IDLE) && !wr_start && rd_new && hit) ? hit_byte : dout_q;
  assign mem_req  = (state_q != IDLE);
  assign mem_we   = (state_q == WR_BUSY);
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign mem_be   = mem_be_q;

  always_comb begin
    state_d       = state_q;
    mem_addr_d    = mem_addr_q;
    mem_din_d     = mem_din_q;
    mem_be_d      = mem_be_q;
    dout_d        = dout_q;
    last_addr_d   = last_addr_q;
    last_valid_d  = last_valid_q;
    pend_addr_d   = pend_addr_q;
    cache_tag_d   = cache_tag_q;
    cache_word_d  = cache_word_q;
    cache_valid_d = cache_valid_q;
    we_prev_d     = we;
    case (state_q)
      IDLE: begin
        if (wr_start) begin
          state_d      = WR_BUSY;
          mem_addr_d   = addr[ADDR_W-1:1];
          mem_din_d    = {din, din};
          mem_be_d     = addr[0] ? 2'b10 : 2'b01;
          last_valid_d = 1'b0;
          // Write-through keeps the cached word coherent with memory.
          if (tag_match) begin
            if (addr[0]) cache_word_d[15:8] = din;
            else         cache_word_d[7:0]  = din;
          end
        end else if (rd_new) begin
          if (hit) begin
            dout_d       = hit_byte;
            last_addr_d  = addr;
            last_valid_d = 1'b1;
          end else begin
            state_d     = RD_BUSY;
            mem_addr_d  = addr[ADDR_W-1:1];
            mem_be_d    = 2'b11;
            pend_addr_d = addr;
          end
        end
      end
      RD_BUSY: begin
        if (mem_ack) begin
          state_d       = IDLE;
          cache_word_d  = mem_dout;
          cache_tag_d   = mem_addr_q;
          cache_valid_d = 1'b1;
          dout_d        = pend_addr_q[0] ? mem_dout[15:8] : mem_dout[7:0];
          last_addr_d   = pend_addr_q;
          last_valid_d  = 1'b1;
        end
      end
      WR_BUSY: begin
        if (mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      mem_addr_q    <= '0;
      mem_din_q     <= '0;
      mem_be_q      <= '0;
      dout_q        <= 8'hFF;
      last_addr_q   <= '0;
      last_valid_q  <= 1'b0;
      pend_addr_q   <= '0;
      cache_tag_q   <= '0;
      cache_word_q  <= '0;
      cache_valid_q <= 1'b0;
      we_prev_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_addr_q    <= mem_addr_d;
      mem_din_q     <= mem_din_d;
      mem_be_q      <= mem_be_d;
      dout_q        <= dout_d;
      last_addr_q   <= last_addr_d;
      last_valid_q  <= last_valid_d;
      pend_addr_q   <= pend_addr_d;
      cache_tag_q   <= cache_tag_d;
      cache_word_q  <= cache_word_d;
      cache_valid_q <= cache_valid_d;
      we_prev_q     <= we_prev_d;
    end
  end

endmodule

// File: tb/tb_slot_mem_port.sv
// Directed bench for slot_mem_port: cached and uncached instances, a word
// memory model with a fixed three-cycle ack latency on the cached instance.
module tb_slot_mem_port;
  localparam int ADDR_W = 25;
  localparam int LAT    = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] addr = '0;
  logic [7:0]        din = '0;
  logic              we = 1'b0;
  logic              rd = 1'b0;

  logic [7:0]        dout, dout2;
  logic              ready, ready2;
  logic [ADDR_W-2:0] mem_addr, mem_addr2;
  logic [15:0]       mem_din, mem_din2;
  logic [1:0]        mem_be, mem_be2;
  logic              mem_we, mem_we2, mem_req, mem_req2;
  logic              mem_ack = 1'b0, mem_ack2 = 1'b0;
  logic [15:0]       mem_dout = '0;
  logic [15:0]       mem_dout2 = 16'hBEEF;

  logic [15:0] mem [0:4095];
  int          cnt = 0;
  int          req_cnt = 0, req_cnt2 = 0;
  logic        req_prev = 1'b0, req_prev2 = 1'b0;
  int          n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  slot_mem_port #(.ADDR_W(ADDR_W), .CACHE_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .addr(addr), .din(din), .we(we), .rd(rd),
    .dout(dout), .ready(ready), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_be(mem_be), .mem_we(mem_we), .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_dout(mem_dout)
  );

  slot_mem_port #(.ADDR_W(ADDR_W), .CACHE_EN(1'b0)) dut_nc (
    .clk(clk), .reset(reset), .addr(addr), .din(din), .we(we), .rd(rd),
    .dout(dout2), .ready(ready2), .mem_addr(mem_addr2), .mem_din(mem_din2),
    .mem_be(mem_be2), .mem_we(mem_we2), .mem_req(mem_req2), .mem_ack(mem_ack2),
    .mem_dout(mem_dout2)
  );

  // Controller model: ack LAT cycles after the request is seen, then
  // apply write bytes or return the read word.
  always @(posedge clk) begin
    if (reset) begin
      cnt     <= 0;
      mem_ack <= 1'b0;
    end else if (mem_req && !mem_ack) begin
      if (cnt == LAT - 1) begin
        cnt      <= 0;
        mem_ack  <= 1'b1;
        mem_dout <= mem[mem_addr[11:0]];
        if (mem_we && mem_be[0]) mem[mem_addr[11:0]][7:0]  <= mem_din[7:0];
        if (mem_we && mem_be[1]) mem[mem_addr[11:0]][15:8] <= mem_din[15:8];
      end else begin
        cnt <= cnt + 1;
      end
    end else begin
      mem_ack <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (reset) mem_ack2 <= 1'b0;
    else       mem_ack2 <= mem_req2 && !mem_ack2;
  end

  always @(posedge clk) begin
    req_prev  <= mem_req;
    req_prev2 <= mem_req2;
    if (mem_req && !req_prev)   req_cnt  <= req_cnt + 1;
    if (mem_req2 && !req_prev2) req_cnt2 <= req_cnt2 + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag, input int max, output int cycles);
    cycles = 0;
    while (!ready && cycles < max) begin
      step();
      cycles++;
    end
    chk(tag, {31'd0, ready}, 32'd1);
  endtask

  initial begin
    int c, base, base2, bad;
    logic [15:0] w;
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    mem[12'h080] = 16'hBEEF;

    repeat (3) step();
    reset = 1'b0;
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_dout", {24'd0, dout}, 32'hFF);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_be_din", {14'd0, mem_be, mem_din}, 32'd0);
    chk("rst_addr", {8'd0, mem_addr}, 32'd0);

    // First read misses: ready falls at once, request next cycle.
    step();
    rd = 1'b1; addr = 25'h000100;
    #1;
    chk("miss_ready0", {31'd0, ready}, 32'd0);
    step();
    chk("miss_req", {31'd0, mem_req}, 32'd1);
    chk("miss_maddr", {8'd0, mem_addr}, 32'h80);
    chk("miss_mwe", {31'd0, mem_we}, 32'd0);
    wait_ready("miss_timeout", 20, c);
    chk("miss_latency", c, 32'd4);
    chk("miss_dout", {24'd0, dout}, 32'hEF);
    chk("miss_req_drop", {31'd0, mem_req}, 32'd0);

    // Neighbouring byte: hit on cached instance, miss on uncached one.
    base = req_cnt; base2 = req_cnt2;
    addr = 25'h000101;
    #1;
    chk("hit_ready", {31'd0, ready}, 32'd1);
    chk("hit_dout", {24'd0, dout}, 32'hBE);
    chk("nc_ready0", {31'd0, ready2}, 32'd0);
    repeat (4) step();
    chk("hit_noreq", req_cnt - base, 32'd0);
    chk("nc_req", req_cnt2 - base2, 32'd1);
    chk("nc_dout", {24'd0, dout2}, 32'hBE);

    // Odd-byte write with write-through into the cached word.
    rd = 1'b0; we = 1'b1; din = 8'h5A;
    #1;
    chk("wr_ready0", {31'd0, ready}, 32'd0);
    step();
    we = 1'b0;
    chk("wr_mwe", {31'd0, mem_we}, 32'd1);
    chk("wr_be", {30'd0, mem_be}, 32'h2);
    chk("wr_din", {16'd0, mem_din}, 32'h5A5A);
    chk("wr_maddr", {8'd0, mem_addr}, 32'h80);
    wait_ready("wr_timeout", 20, c);
    w = mem[12'h080];
    chk("wr_mem", {16'd0, w}, 32'h5AEF);
    base = req_cnt;
    rd = 1'b1; addr = 25'h000100;
    #1;
    chk("coh_ready", {31'd0, ready}, 32'd1);
    chk("coh_dout_lo", {24'd0, dout}, 32'hEF);
    step();
    addr = 25'h000101;
    #1;
    chk("coh_dout_hi", {24'd0, dout}, 32'h5A);
    repeat (2) step();
    chk("coh_noreq", req_cnt - base, 32'd0);

    // 256-byte write burst, one rising we per completed write.
    rd = 1'b0;
    base = req_cnt;
    for (int i = 0; i < 256; i++) begin
      addr = 25'h001000 + 25'(i); din = 8'(i); we = 1'b1;
      step();
      we = 1'b0;
      wait_ready("burst_timeout", 20, c);
      step();
    end
    chk("burst_reqs", req_cnt - base, 32'd256);
    bad = 0;
    for (int i = 0; i < 128; i++) begin
      w = mem[12'h800 + 12'(i)];
      if (w !== {8'(2 * i + 1), 8'(2 * i)}) bad++;
    end
    chk("burst_data", bad, 32'd0);

    // rd and we rise together: write goes out first, then the read.
    base = req_cnt;
    addr = 25'h001010; din = 8'h77; rd = 1'b1; we = 1'b1;
    #1;
    chk("rw_ready0", {31'd0, ready}, 32'd0);
    step();
    we = 1'b0;
    chk("rw_write_first", {31'd0, mem_we}, 32'd1);
    wait_ready("rw_timeout", 40, c);
    chk("rw_dout", {24'd0, dout}, 32'h77);
    chk("rw_reqs", req_cnt - base, 32'd2);
    w = mem[12'h808];
    chk("rw_mem", {16'd0, w}, 32'h1177);

    // A we edge during a read is dropped, not queued.
    base = req_cnt;
    addr = 25'h001020; din = 8'hAA;
    step();
    we = 1'b1;
    step();
    we = 1'b0;
    wait_ready("busywe_timeout", 20, c);
    repeat (3) step();
    chk("busywe_reqs", req_cnt - base, 32'd1);
    chk("busywe_dout", {24'd0, dout}, 32'h20);
    w = mem[12'h810];
    chk("busywe_mem", {16'd0, w}, 32'h2120);

    // Reset while RD_BUSY.
    addr = 25'h001030;
    step();
    chk("rstmid_req1", {31'd0, mem_req}, 32'd1);
    reset = 1'b1; rd = 1'b0;
    #1;
    chk("rstmid_req0", {31'd0, mem_req}, 32'd0);
    chk("rstmid_ready", {31'd0, ready}, 32'd1);
    chk("rstmid_dout", {24'd0, dout}, 32'hFF);
    chk("rstmid_be", {30'd0, mem_be}, 32'd0);
    step();
    reset = 1'b0;
    step();
    rd = 1'b1; addr = 25'h001021;
    #1;
    chk("postrst_miss", {31'd0, ready}, 32'd0);
    wait_ready("postrst_timeout", 20, c);
    chk("postrst_dout", {24'd0, dout}, 32'h21);
    addr = 25'h001030;
    #1;
    chk("postrst_miss2", {31'd0, ready}, 32'd0);
    wait_ready("postrst2_timeout", 20, c);
    chk("postrst_dout2", {24'd0, dout}, 32'h30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
